axis_bram_writer: RTL and testbench
===================================

Name: axis_bram_writer

Overview:
- AXI-Stream slave that writes incoming beats into a simple-dual/true-dual BRAM port at consecutive addresses starting at 0.
- Write-side counterpart of the stream-from-BRAM reader: software arms a capture of `limit` words; the block fills the buffer, then the reader or a CPU can drain it.
- Supports one-shot capture (stop at limit or tlast) and continuous ring mode (wrap to 0).

Parameters:
- DATA_WIDTH, 16, width of stream data and BRAM word in bits (multiple of 8).
- ADDR_WIDTH, 12, BRAM word-address width.

Ports:
- aclk  in  1  clock for stream, BRAM port and control.
- aresetn  in  1  asynchronous active-low reset.
- limit  in  ADDR_WIDTH  number of words per pass; 0 means 2^ADDR_WIDTH.
- arm  in  1  single-cycle pulse starting a capture.
- continuous  in  1  1 = wrap to 0 at limit and keep writing; 0 = one-shot.
- stop_on_tlast  in  1  1 = a beat with tlast ends the pass.
- s_axis_tdata  in  DATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tlast  in  1  stream last.
- s_axis_tready  out  1  stream ready.
- bram_wrdata  out  DATA_WIDTH  BRAM write data.
- bram_addr  out  ADDR_WIDTH  BRAM word address.
- bram_we  out  DATA_WIDTH/8  BRAM byte write enables, all-ones or all-zeros.
- bram_en  out  1  BRAM port enable.
- bram_clk  out  1  BRAM clock, equal to aclk.
- wr_count  out  ADDR_WIDTH+1  words written in the current or last pass.
- busy  out  1  high in CAPTURE.
- done  out  1  one-cycle pulse when a pass completes.

Behaviour:
- Reset (aresetn low, asynchronous) forces the following, and aborts any pass with no partial-write completion:
  - state = IDLE;
  - s_axis_tready, bram_we, bram_en, busy, done = 0;
  - bram_addr, bram_wrdata, wr_count, write pointer = 0.
- bram_clk = aclk combinationally in all states.
- Internal limit: on arm, latch lim_int = (limit == 0) ? 2^ADDR_WIDTH : limit, ADDR_WIDTH+1 bits wide. limit is ignored at all other times.
- States:
  - IDLE:
    - s_axis_tready = 0.
    - arm -> CAPTURE; write pointer and wr_count cleared to 0.
  - CAPTURE:
    - s_axis_tready = 1 combinationally; beats are accepted every cycle, so there is no backpressure.
    - Handshake = tvalid && tready.
    - On handshake, next edge: bram_addr <= pointer, bram_wrdata <= tdata, bram_we <= all-ones, bram_en <= 1, pointer++, wr_count++.
    - Without a handshake, next edge: bram_we <= 0 and bram_en <= 0.
    - Write latency is exactly 1 cycle from handshake to we on the BRAM port.
  - End of pass: triggered by the handshake beat for which pointer == lim_int-1, or by a tlast beat when stop_on_tlast = 1. That beat is always written.
    - continuous = 0: next state DONE. The block accepts no further beats, so tready is low the following cycle.
    - continuous = 1: pointer wraps to 0 and the state stays CAPTURE. done pulses and wr_count restarts at 1 on the next beat, so wr_count shows lim_int for exactly the done cycle.
  - DONE:
    - Lasts one cycle: done = 1, tready = 0, and bram_we returns to 0 (after the final write cycle).
    - Then IDLE. wr_count holds its final value until the next arm.
- arm while busy: ignored.
- arm in the DONE cycle: honoured; the next state is CAPTURE.
- Pointer arithmetic: ADDR_WIDTH+1 bit compare against lim_int. A full 2^ADDR_WIDTH pass writes addresses 0..2^ADDR_WIDTH-1, with no address alias before wrap.
- tlast with stop_on_tlast = 0: written as ordinary data and has no control effect.
- Simultaneous limit-reach and tlast: a single end-of-pass, with done pulsed once.

Test Plan:
- One-shot, limit=4: arm, then stream values 0xA0..0xA5 continuously.
  - Required: writes 0xA0..0xA3 to addresses 0..3, each with we=0x3 one cycle after its handshake.
  - Required: done pulses once, wr_count=4, tready falls after the 4th beat, and 0xA4 is not accepted.
- stop_on_tlast=1, limit=8: send 3 beats with tlast on the 3rd.
  - Required: addresses 0..2 written, done pulses, wr_count=3.
  - Required: tlast on beat 8 with limit=8 gives a single done.
- continuous=1, limit=3: stream 7 beats D0..D6 with tvalid gaps inserted.
  - Required: address sequence 0,1,2,0,1,2,0; done pulses after D2 and after D5.
  - Required: we stays low in gap cycles.
- limit=0, ADDR_WIDTH=4: 17 beats.
  - Required: addresses 0..15, done after 16 beats, wr_count=16, 17th beat is not accepted.
- Reset mid-pass: assert aresetn=0 asynchronously between clock edges after 2 beats.
  - Required: we, en, tready and busy drop immediately; wr_count=0.
  - Required: after release and re-arm, writing restarts at address 0.
- arm pulse during CAPTURE is ignored, and the pass length is unchanged even if limit changes mid-pass.

Source files
------------

// File: rtl/axis_bram_writer.sv
// ---------------------------------------------------------------------------
// axis_bram_writer
//
// AXI-Stream slave that writes accepted beats into a BRAM port at consecutive
// word addresses starting at 0. Software arms a capture of `limit` words
// (0 = 2^ADDR_WIDTH). A pass ends at the limit or, optionally, on tlast.
// In one-shot mode the block then returns to idle. In continuous mode the
// pointer wraps to 0 and capture carries on.
//
// Ports
//   aclk, aresetn      clock, async active-low reset
//   limit              words per pass, latched on arm (0 = 2^ADDR_WIDTH)
//   arm                one-cycle pulse, starts a pass from idle or done
//   continuous         1 = ring mode, 0 = one-shot
//   stop_on_tlast      1 = a tlast beat ends the pass
//   s_axis_*           stream slave (never backpressures while capturing)
//   bram_*             BRAM write port; bram_clk is aclk
//   wr_count           words written in the current/last pass
//   busy               high while capturing
//   done               one-cycle pulse when a pass completes
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for arm, stream not ready
// CAPTURE | accepting every beat, one BRAM write per beat
// DONE    | one-shot pass finished, done high for this single cycle
// ---------------------------------------------------------------------------
module axis_bram_writer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [ADDR_WIDTH-1:0]     limit,
   input  logic                      arm,
   input  logic                      continuous,
   input  logic                      stop_on_tlast,
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic                      s_axis_tvalid,
   input  logic                      s_axis_tlast,
   output logic                      s_axis_tready,
   output logic [DATA_WIDTH-1:0]     bram_wrdata,
   output logic [ADDR_WIDTH-1:0]     bram_addr,
   output logic [DATA_WIDTH/8-1:0]   bram_we,
   output logic                      bram_en,
   output logic                      bram_clk,
   output logic [ADDR_WIDTH:0]       wr_count,
   output logic                      busy,
   output logic                      done
);

   localparam int WE_W = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH:0]   ptr;
   logic [ADDR_WIDTH:0]   ptr_inc;
   logic [ADDR_WIDTH:0]   lim_int;
   logic [ADDR_WIDTH:0]   lim_arm;
   logic                  hs;
   logic                  eop;

   assign bram_clk      = aclk;
   assign s_axis_tready = (state == ST_CAPTURE);
   assign busy          = (state == ST_CAPTURE);

   assign hs      = s_axis_tvalid && s_axis_tready;
   assign ptr_inc = ptr + CNT_ONE;
   // ptr is one bit wider than the address so a full 2^ADDR_WIDTH pass
   // compares cleanly without aliasing address 0.
   assign eop     = (ptr_inc == lim_int) || (stop_on_tlast && s_axis_tlast);
   assign lim_arm = (limit == '0) ? CNT_FULL : {1'b0, limit};

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         lim_int     <= '0;
         bram_addr   <= '0;
         bram_wrdata <= '0;
         bram_we     <= '0;
         bram_en     <= 1'b0;
         wr_count    <= '0;
         done        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               bram_we <= '0;
               bram_en <= 1'b0;
               done    <= 1'b0;
               if (arm) begin
                  state    <= ST_CAPTURE;
                  ptr      <= '0;
                  wr_count <= '0;
                  lim_int  <= lim_arm;
               end
            end

            ST_CAPTURE: begin
               if (hs) begin
                  bram_addr   <= ptr[ADDR_WIDTH-1:0];
                  bram_wrdata <= s_axis_tdata;
                  bram_we     <= {WE_W{1'b1}};
                  bram_en     <= 1'b1;
                  // done still high means the previous beat closed a ring
                  // pass, so this beat is the first of the new one.
                  wr_count    <= done ? CNT_ONE : (wr_count + CNT_ONE);
                  done        <= eop;
                  if (eop) begin
                     ptr <= '0;
                     if (!continuous) state <= ST_DONE;
                  end else begin
                     ptr <= ptr_inc;
                  end
               end else begin
                  bram_we <= '0;
                  bram_en <= 1'b0;
                  done    <= 1'b0;
                  // ring pass closed and no beat followed: show the fresh
                  // pass as empty so lim_int is visible for the done cycle only
                  if (done) wr_count <= '0;
               end
            end

            ST_DONE: begin
               bram_we <= '0;
               bram_en <= 1'b0;
               done    <= 1'b0;
               if (arm) begin
                  state    <= ST_CAPTURE;
                  ptr      <= '0;
                  wr_count <= '0;
                  lim_int  <= lim_arm;
               end else begin
                  state <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_bram_writer.sv
module tb_axis_bram_writer;

   localparam int DW = 16;
   localparam int AW = 4;

   logic           aclk;
   logic           aresetn;
   logic [AW-1:0]  limit;
   logic           arm;
   logic           continuous;
   logic           stop_on_tlast;
   logic [DW-1:0]  s_axis_tdata;
   logic           s_axis_tvalid;
   logic           s_axis_tlast;
   logic           s_axis_tready;
   logic [DW-1:0]  bram_wrdata;
   logic [AW-1:0]  bram_addr;
   logic [DW/8-1:0] bram_we;
   logic           bram_en;
   logic           bram_clk;
   logic [AW:0]    wr_count;
   logic           busy;
   logic           done;

   axis_bram_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .limit         (limit),
      .arm           (arm),
      .continuous    (continuous),
      .stop_on_tlast (stop_on_tlast),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .bram_wrdata   (bram_wrdata),
      .bram_addr     (bram_addr),
      .bram_we       (bram_we),
      .bram_en       (bram_en),
      .bram_clk      (bram_clk),
      .wr_count      (wr_count),
      .busy          (busy),
      .done          (done)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          eop;
      logic [AW:0]   wc;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   int n_chk  = 0;
   int n_pass = 0;
   int n_done = 0;
   int exp_done_total = 0;

   // reference model
   bit m_active = 0;
   bit m_cont   = 0;
   bit m_sot    = 0;
   int m_lim    = 0;
   int m_ptr    = 0;
   int m_cnt    = 0;

   logic exp_hs = 1'b0;
   logic hs_q;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) hs_q <= 1'b0;
      else          hs_q <= exp_hs;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   // write-port monitor: one cycle after each accepted beat a write must appear
   always @(negedge aclk) begin
      if (hs_q === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("we",       32'(bram_we),     32'h3);
            chk("en",       32'(bram_en),     32'h1);
            chk("addr",     32'(bram_addr),   32'(e.addr));
            chk("data",     32'(bram_wrdata), 32'(e.data));
            chk("done",     32'(done),        32'(e.eop));
            chk("wr_count", 32'(wr_count),    32'(e.wc));
         end
      end else begin
         chk("we_idle",   32'(bram_we), 32'h0);
         chk("en_idle",   32'(bram_en), 32'h0);
         chk("done_idle", 32'(done),    32'h0);
      end
      if (done === 1'b1) n_done++;
   end

   task automatic do_arm(input int l, input bit cont, input bit sot);
      @(negedge aclk);
      arm = 1'b1; limit = AW'(l); continuous = cont; stop_on_tlast = sot;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; exp_hs = 1'b0;
      if (!m_active) begin
         m_active = 1; m_cont = cont; m_sot = sot;
         m_lim = (l == 0) ? (1 << AW) : l;
         m_ptr = 0; m_cnt = 0;
      end
   endtask

   task automatic beat(input logic [DW-1:0] d, input bit last);
      bit eop;
      @(negedge aclk);
      arm = 1'b0;
      s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = last;
      chk("tready", 32'(s_axis_tready), 32'(m_active));
      chk("busy",   32'(busy),          32'(m_active));
      if (m_active) begin
         exp_hs = 1'b1;
         m_cnt++;
         eop = (m_ptr == m_lim - 1) || (m_sot && last);
         sb.push_back('{addr: AW'(m_ptr), data: d, eop: eop, wc: (AW+1)'(m_cnt)});
         if (eop) begin
            exp_done_total++;
            m_ptr = 0;
            m_cnt = 0;
            if (!m_cont) m_active = 0;
         end else begin
            m_ptr++;
         end
      end else begin
         exp_hs = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge aclk);
         arm = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; exp_hs = 1'b0;
      end
   endtask

   task automatic do_reset();
      idle(1);
      @(negedge aclk);
      aresetn = 1'b0;
      m_active = 0;
      sb.delete();
      @(negedge aclk);
      aresetn = 1'b1;
   endtask

   initial begin
      aresetn = 1'b0; limit = '0; arm = 1'b0; continuous = 1'b0;
      stop_on_tlast = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      #12;
      chk("rst_tready",   32'(s_axis_tready), 0);
      chk("rst_we",       32'(bram_we),       0);
      chk("rst_en",       32'(bram_en),       0);
      chk("rst_busy",     32'(busy),          0);
      chk("rst_done",     32'(done),          0);
      chk("rst_addr",     32'(bram_addr),     0);
      chk("rst_wrdata",   32'(bram_wrdata),   0);
      chk("rst_wr_count", 32'(wr_count),      0);
      @(negedge aclk);
      aresetn = 1'b1;

      // one-shot, limit 4, six beats offered back to back
      do_arm(4, 0, 0);
      for (int i = 0; i < 6; i++) beat(DW'(16'hA0 + i), 1'b0);
      idle(3);
      chk("t1_wr_count", 32'(wr_count), 4);
      chk("t1_sb_empty", 32'(sb.size()), 0);

      // tlast ends the pass early
      do_arm(8, 0, 1);
      beat(16'hB0, 1'b0);
      beat(16'hB1, 1'b0);
      beat(16'hB2, 1'b1);
      beat(16'hB3, 1'b0);
      idle(3);
      chk("t2_wr_count", 32'(wr_count), 3);

      // tlast on the limit beat: one end of pass
      do_arm(8, 0, 1);
      for (int i = 0; i < 8; i++) beat(DW'(16'hC0 + i), i == 7);
      idle(3);
      chk("t2b_wr_count", 32'(wr_count), 8);

      // tlast without stop_on_tlast is plain data
      do_arm(3, 0, 0);
      beat(16'hC8, 1'b1);
      beat(16'hC9, 1'b0);
      beat(16'hCA, 1'b0);
      idle(3);
      chk("t2c_wr_count", 32'(wr_count), 3);

      // limit 0 = full 16-word buffer
      do_arm(0, 0, 0);
      for (int i = 0; i < 17; i++) beat(DW'(16'h100 + i), 1'b0);
      idle(3);
      chk("t4_wr_count", 32'(wr_count), 16);

      // arm and limit changes during capture are ignored
      do_arm(5, 0, 0);
      beat(16'hD0, 1'b0);
      beat(16'hD1, 1'b0);
      @(negedge aclk);
      arm = 1'b1; limit = 4'd2; s_axis_tvalid = 1'b0; exp_hs = 1'b0;
      for (int i = 2; i < 6; i++) beat(DW'(16'hD0 + i), 1'b0);
      idle(3);
      chk("t6_wr_count", 32'(wr_count), 5);

      // continuous ring, limit 3, with valid gaps
      do_arm(3, 1, 0);
      beat(16'hE0, 1'b0); idle(1);
      beat(16'hE1, 1'b0); beat(16'hE2, 1'b0); idle(2);
      beat(16'hE3, 1'b0); beat(16'hE4, 1'b0); idle(1);
      beat(16'hE5, 1'b0); beat(16'hE6, 1'b0);
      idle(2);
      chk("t3_busy", 32'(busy), 1);
      chk("t3_sb_empty", 32'(sb.size()), 0);
      do_reset();

      // asynchronous reset in the middle of a pass
      do_arm(8, 0, 0);
      beat(16'hF1, 1'b0);
      beat(16'hF2, 1'b0);
      @(posedge aclk);
      #1;
      chk("t5_we_before", 32'(bram_we), 32'h3);
      #1;
      aresetn = 1'b0;
      s_axis_tvalid = 1'b0; exp_hs = 1'b0; m_active = 0;
      sb.delete();
      #1;
      chk("t5_we",       32'(bram_we),       0);
      chk("t5_en",       32'(bram_en),       0);
      chk("t5_tready",   32'(s_axis_tready), 0);
      chk("t5_busy",     32'(busy),          0);
      chk("t5_wr_count", 32'(wr_count),      0);
      @(negedge aclk);
      aresetn = 1'b1;
      do_arm(2, 0, 0);
      beat(16'hF3, 1'b0);
      beat(16'hF4, 1'b0);
      idle(3);
      chk("t5_wr_count_after", 32'(wr_count), 2);
      chk("sb_final_empty", 32'(sb.size()), 0);
      chk("done_pulses", 32'(n_done), 32'(exp_done_total));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
